// File: rtl/data_mem_pkg.sv
// Shared constants, owner encoding and address-window check for the data memory arbiter.
package data_mem_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_BASE  = 64;
  localparam int unsigned MEM_LIMIT = 127;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  // True when addr lies inside the legal data-memory window [base, limit].
  function automatic logic in_range(input int unsigned addr,
                                    input int unsigned base  = MEM_BASE,
                                    input int unsigned limit = MEM_LIMIT);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. rr_last remembers the most recently granted port so the
// other port wins the next contest; reset leaves B as last so A wins first.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  owner_t rr_last_q;

  // Grant decision: a lone request wins, a contest goes to the port that did not win last.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      gnt_a = req_a && (!req_b || (rr_last_q == OWN_B));
      gnt_b = req_b && (!req_a || (rr_last_q == OWN_A));
    end
  end

  // Track the last granted port; unchanged on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= OWN_B;
    end else if (gnt_a) begin
      rr_last_q <= OWN_A;
    end else if (gnt_b) begin
      rr_last_q <= OWN_B;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port, registered-read data memory between a CPU port (A) and a debug
// port (B). One access is granted per cycle; completion is signalled exactly one cycle
// after the grant on the port that owned it, with an error flag for out-of-window accesses.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = data_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W    = data_mem_pkg::DATA_W,
  parameter int unsigned MEM_BASE  = data_mem_pkg::MEM_BASE,
  parameter int unsigned MEM_LIMIT = data_mem_pkg::MEM_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  // Port A: CPU load/store
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  // Port B: debug / boot loader
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  // Data memory
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  import data_mem_pkg::*;

  logic              gnt_a;
  logic              gnt_b;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_in_range;
  owner_t            sel_owner;

  logic              pend_valid_q;
  owner_t            pend_owner_q;
  logic              pend_we_q;
  logic              pend_err_q;

  logic              own_a;
  logic              own_b;
  logic [DATA_W-1:0] rd_val;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_a (a_req),
    .req_b (b_req),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign a_gnt = gnt_a;
  assign b_gnt = gnt_b;
  assign grant = gnt_a || gnt_b;

  // Select the granted port's fields; idle cycles park the memory on a harmless read.
  always_comb begin
    sel_addr  = ADDR_W'(MEM_BASE);
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_owner = OWN_A;
    if (gnt_a) begin
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
      sel_we    = a_we;
      sel_owner = OWN_A;
    end else if (gnt_b) begin
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
      sel_we    = b_we;
      sel_owner = OWN_B;
    end
  end

  // Out-of-window writes never reach the memory.
  always_comb begin
    sel_in_range     = in_range(32'(sel_addr), MEM_BASE, MEM_LIMIT);
    mem_address      = sel_addr;
    mem_write_data   = sel_wdata;
    mem_write_enable = sel_we && sel_in_range;
  end

  // Pending register: remembers who was granted so the response lands one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_owner_q <= OWN_A;
      pend_we_q    <= 1'b0;
      pend_err_q   <= 1'b0;
    end else begin
      pend_valid_q <= grant;
      if (grant) begin
        pend_owner_q <= sel_owner;
        pend_we_q    <= sel_we;
        pend_err_q   <= !sel_in_range;
      end
    end
  end

  // Route the completion to the owner; reset in the response cycle swallows the pulse.
  always_comb begin
    own_a   = pend_valid_q && !reset && (pend_owner_q == OWN_A);
    own_b   = pend_valid_q && !reset && (pend_owner_q == OWN_B);
    rd_val  = (!pend_we_q && !pend_err_q) ? mem_read_data : '0;
    a_done  = own_a;
    a_err   = own_a && pend_err_q;
    a_rdata = own_a ? rd_val : '0;
    b_done  = own_b;
    b_err   = own_b && pend_err_q;
    b_rdata = own_b ? rd_val : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed vectors push expected completions,
// a monitor pops and compares whenever a done pulse is due or appears.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_write_enable;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    bit         port_b;
    logic       err;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // Memory model: unwritten locations read as addr ^ 0xA5.
  logic [7:0] mem [256];
  bit         written [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) begin
      mem[mem_address]     <= mem_write_data;
      written[mem_address] <= 1'b1;
    end
    mem_read_data <= written[mem_address] ? mem[mem_address] : (mem_address ^ 8'hA5);
  end

  data_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .a_req            (a_req),
    .a_we             (a_we),
    .a_addr           (a_addr),
    .a_wdata          (a_wdata),
    .a_gnt            (a_gnt),
    .a_done           (a_done),
    .a_rdata          (a_rdata),
    .a_err            (a_err),
    .b_req            (b_req),
    .b_we             (b_we),
    .b_addr           (b_addr),
    .b_wdata          (b_wdata),
    .b_gnt            (b_gnt),
    .b_done           (b_done),
    .b_rdata          (b_rdata),
    .b_err            (b_err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus. Entered at posedge+1, returns at the next posedge+1.
  task automatic drv(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                     input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                     input logic ega, input logic egb, input logic ewe, input logic [7:0] eaddr,
                     input bit push, input logic eerr, input logic [7:0] erd);
    exp_t e;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    chk("a_gnt", a_gnt, ega);
    chk("b_gnt", b_gnt, egb);
    chk("mem_write_enable", mem_write_enable, ewe);
    chk("mem_address", mem_address, eaddr);
    if (push) begin
      e.due = cyc + 1; e.port_b = egb; e.err = eerr; e.rdata = erd;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'd64, 0, 0, 8'h00);
  endtask

  // Monitor: a done pulse must appear exactly when an expectation falls due, never otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.port_b) begin
          chk("b_done", b_done, 1);
          chk("a_done_idle", a_done, 0);
          chk("b_err", b_err, e.err);
          chk("b_rdata", b_rdata, e.rdata);
        end else begin
          chk("a_done", a_done, 1);
          chk("b_done_idle", b_done, 0);
          chk("a_err", a_err, e.err);
          chk("a_rdata", a_rdata, e.rdata);
        end
      end else if (a_done || b_done) begin
        chk("spurious_done", {a_done, b_done}, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {a_done, b_done, a_err, b_err}, 4'b0000);
    chk("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
    chk("rst_gnt", {a_gnt, b_gnt}, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // A write 64 <- 5A, then read it back.
    drv(1, 1, 8'd64, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'd64, 1, 0, 8'h00);
    drv(1, 0, 8'd64, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'd64, 1, 0, 8'h5A);
    // B read 64 so B is last; the contest then runs A, B, A.
    drv(0, 0, 8'h00, 8'h00, 1, 0, 8'd64, 8'h00, 0, 1, 0, 8'd64, 1, 0, 8'h5A);
    drv(1, 0, 8'd65, 8'h00, 1, 1, 8'd66, 8'h11, 1, 0, 0, 8'd65, 1, 0, 8'hE4);
    drv(1, 0, 8'd65, 8'h00, 1, 1, 8'd66, 8'h11, 0, 1, 1, 8'd66, 1, 0, 8'h00);
    drv(1, 0, 8'd65, 8'h00, 1, 1, 8'd66, 8'h22, 1, 0, 0, 8'd65, 1, 0, 8'hE4);
    // B drops its ungranted request: no done for it.
    idle(1);
    drv(1, 0, 8'd66, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'd66, 1, 0, 8'h11);

    // Out-of-window accesses: no write, err set, rdata zero.
    drv(0, 0, 8'h00, 8'h00, 1, 1, 8'd63, 8'h77, 0, 1, 0, 8'd63, 1, 1, 8'h00);
    drv(0, 0, 8'h00, 8'h00, 1, 1, 8'd128, 8'h77, 0, 1, 0, 8'd128, 1, 1, 8'h00);
    drv(0, 0, 8'h00, 8'h00, 1, 0, 8'd63, 8'h00, 0, 1, 0, 8'd63, 1, 1, 8'h00);
    drv(1, 0, 8'd64, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'd64, 1, 0, 8'h5A);

    // Back-to-back write then read at the upper boundary.
    drv(1, 1, 8'd127, 8'hC3, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'd127, 1, 0, 8'h00);
    drv(1, 0, 8'd127, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'd127, 1, 0, 8'hC3);
    idle(1);

    // Reset in the response cycle swallows the done; then A wins the first contest.
    drv(1, 0, 8'd64, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'd64, 0, 0, 8'h00);
    reset = 1'b1;
    a_req = 1; a_we = 0; a_addr = 8'd64;
    b_req = 1; b_we = 0; b_addr = 8'd127;
    @(negedge clk);
    chk("rst_mid_a_done", a_done, 0);
    chk("rst_mid_gnt", {a_gnt, b_gnt}, 2'b00);
    @(posedge clk);
    #1;
    drv(1, 0, 8'd64, 8'h00, 1, 0, 8'd127, 8'h00, 0, 0, 0, 8'd64, 0, 0, 8'h00);
    reset = 1'b0;
    drv(1, 0, 8'd64, 8'h00, 1, 0, 8'd127, 8'h00, 1, 0, 0, 8'd64, 1, 0, 8'h5A);
    drv(0, 0, 8'h00, 8'h00, 1, 0, 8'd127, 8'h00, 0, 1, 0, 8'd127, 1, 0, 8'hC3);
    idle(3);

    chk("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
